// File: rtl/rsa_key_gen.sv
`default_nettype none
// ============================================================================
// Module   : rsa_key_gen
// Brief    : Sequential RSA private-key generator. Computes n = p*q,
//            phi = (p-1)*(q-1) and d = e^-1 mod phi with an iterative
//            extended Euclid built around one shared restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_key_gen #(
  parameter int P_W = 4,
  parameter int E_W = 9,
  parameter int N_W = 2 * P_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [P_W-1:0] p,
  input  logic [P_W-1:0] q,
  input  logic [E_W-1:0] e,
  output logic           busy,
  output logic           done,
  output logic           key_valid,
  output logic           key_err,
  output logic [N_W-1:0] n,
  output logic [N_W-1:0] d
);

  localparam int c_CW = (E_W > 1) ? $clog2(E_W) : 1;
  localparam logic [c_CW-1:0]  c_CNT_LOAD = c_CW'(E_W - 1);
  localparam logic [N_W+1:0]   c_T_ONE    = {{(N_W+1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_REDUCE = 3'd2,
    S_CHECK  = 3'd3,
    S_DIV    = 3'd4,
    S_UPDATE = 3'd5,
    S_FINISH = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  // Captured operands and derived totient
  logic [P_W-1:0] r_p;
  logic [P_W-1:0] r_q;
  logic [E_W-1:0] r_e;
  logic [N_W-1:0] r_phi;
  logic           r_err;

  // Euclid remainders and signed Bezout coefficients
  logic [N_W-1:0]        r_r0;
  logic [N_W-1:0]        r_r1;
  logic signed [N_W+1:0] r_t0;
  logic signed [N_W+1:0] r_t1;

  // Shared restoring divider: r_dvd shifts the dividend out and the quotient in
  logic [E_W-1:0]  r_dvd;
  logic [N_W-1:0]  r_dvs;
  logic [N_W-1:0]  r_rem;
  logic [c_CW-1:0] r_cnt;

  logic [N_W-1:0]        w_phi;
  logic                  w_setup_err;
  logic [N_W:0]          w_shift;
  logic                  w_ge;
  logic [N_W-1:0]        w_rem_nx;
  logic signed [N_W+1:0] w_qt_s;
  logic signed [N_W+1:0] w_prod;

  // p or q below 2 wraps p-1/q-1, but that case is flagged as an error anyway
  assign w_phi       = N_W'(r_p - P_W'(1)) * N_W'(r_q - P_W'(1));
  assign w_setup_err = (r_p < P_W'(2)) || (r_q < P_W'(2)) || (w_phi < N_W'(2));

  // Partial remainder stays below the divisor, so N_W bits hold it after each step
  assign w_shift  = {r_rem, r_dvd[E_W-1]};
  assign w_ge     = (w_shift >= {1'b0, r_dvs});
  assign w_rem_nx = w_ge ? N_W'(w_shift - {1'b0, r_dvs}) : w_shift[N_W-1:0];

  // Quotient of r0/r1 never exceeds N_W bits; product truncation is safe as |t| <= phi
  assign w_qt_s = signed'({2'b00, r_dvd[N_W-1:0]});
  assign w_prod = w_qt_s * r_t1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  // Next-state decode and status outputs
  always_comb begin
    w_state_nx = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_state_nx = S_SETUP;
      S_SETUP:  begin
        busy       = 1'b1;
        w_state_nx = w_setup_err ? S_FINISH : S_REDUCE;
      end
      S_REDUCE: begin
        busy = 1'b1;
        if (r_cnt == '0) w_state_nx = S_CHECK;
      end
      S_CHECK:  begin
        busy       = 1'b1;
        w_state_nx = (r_r1 == '0) ? S_FINISH : S_DIV;
      end
      S_DIV:    begin
        busy = 1'b1;
        if (r_cnt == '0) w_state_nx = S_UPDATE;
      end
      S_UPDATE: begin
        busy       = 1'b1;
        w_state_nx = S_CHECK;
      end
      S_FINISH: begin
        busy       = 1'b1;
        w_state_nx = S_DONE;
      end
      S_DONE:   begin
        done       = 1'b1;
        w_state_nx = S_IDLE;
      end
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // Datapath: operand capture, divider stepping, Euclid update and result latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p       <= '0;
      r_q       <= '0;
      r_e       <= '0;
      r_phi     <= '0;
      r_err     <= 1'b0;
      r_r0      <= '0;
      r_r1      <= '0;
      r_t0      <= '0;
      r_t1      <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      n         <= '0;
      d         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_p       <= p;
            r_q       <= q;
            r_e       <= e;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
          end
        end
        S_SETUP: begin
          r_phi <= w_phi;
          r_err <= w_setup_err;
          r_dvd <= r_e;
          r_dvs <= w_phi;
          r_rem <= '0;
          r_cnt <= c_CNT_LOAD;
        end
        S_REDUCE, S_DIV: begin
          r_dvd <= {r_dvd[E_W-2:0], w_ge};
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt - c_CW'(1);
          // Final reduction step seeds the Euclid state with e mod phi
          if (r_state == S_REDUCE && r_cnt == '0) begin
            r_r0 <= r_phi;
            r_r1 <= w_rem_nx;
            r_t0 <= '0;
            r_t1 <= c_T_ONE;
          end
        end
        S_CHECK: begin
          r_dvd <= E_W'(r_r0);
          r_dvs <= r_r1;
          r_rem <= '0;
          r_cnt <= c_CNT_LOAD;
        end
        S_UPDATE: begin
          r_r0 <= r_r1;
          r_r1 <= r_rem;
          r_t0 <= r_t1;
          r_t1 <= r_t0 - w_prod;
        end
        S_FINISH: begin
          n <= N_W'(r_p) * N_W'(r_q);
          if (r_err || r_r0 != N_W'(1)) begin
            key_err <= 1'b1;
            d       <= '0;
          end else begin
            key_valid <= 1'b1;
            d         <= r_t0[N_W+1] ? (r_t0[N_W-1:0] + r_phi) : r_t0[N_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rsa_key_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_key_gen
// Brief    : Self-checking bench for rsa_key_gen with an expected-result queue
//            and a brute-force modular-inverse reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_key_gen;

  localparam int P_W = 4;
  localparam int E_W = 9;
  localparam int N_W = 2 * P_W;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [P_W-1:0] p;
  logic [P_W-1:0] q;
  logic [E_W-1:0] e;
  logic           busy;
  logic           done;
  logic           key_valid;
  logic           key_err;
  logic [N_W-1:0] n;
  logic [N_W-1:0] d;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int n;
    int d;
    int e;
    int phi;
    bit valid;
    bit err;
  } exp_t;

  exp_t sb[$];

  rsa_key_gen #(.P_W(P_W), .E_W(E_W), .N_W(N_W)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .start     (start),
    .p         (p),
    .q         (q),
    .e         (e),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .key_err   (key_err),
    .n         (n),
    .d         (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: inverse found by exhaustive search, independent of Euclid
  function automatic exp_t model(input int pp, input int qq, input int ee);
    exp_t r;
    r.n     = pp * qq;
    r.phi   = (pp - 1) * (qq - 1);
    r.e     = ee;
    r.d     = 0;
    r.valid = 1'b0;
    r.err   = 1'b1;
    if (pp >= 2 && qq >= 2 && r.phi >= 2) begin
      for (int k = 1; k < r.phi; k++) begin
        if ((ee * k) % r.phi == 1) begin
          r.d     = k;
          r.valid = 1'b1;
          r.err   = 1'b0;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic do_start(input int pp, input int qq, input int ee);
    @(negedge clk);
    p     = P_W'(pp);
    q     = Q_cast(qq);
    e     = E_W'(ee);
    start = 1'b1;
    sb.push_back(model(pp, qq, ee));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_cleared", key_valid, 0);
    check("err_cleared", key_err, 0);
  endtask

  function automatic logic [P_W-1:0] Q_cast(input int v);
    return P_W'(v);
  endfunction

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("done_within_200", (cyc < 200), 1);
  endtask

  // Compare the DUT result with the oldest expectation; optionally poke start during DONE
  task automatic check_result(input string tag, input bit poke);
    exp_t x;
    x = sb.pop_front();
    if (poke) begin
      p     = 4'd7;
      q     = 4'd7;
      e     = 9'd5;
      start = 1'b1;
    end
    check({tag, "_n"}, n, x.n);
    check({tag, "_d"}, d, x.d);
    check({tag, "_valid"}, key_valid, x.valid);
    check({tag, "_err"}, key_err, x.err);
    if (x.valid) begin
      check({tag, "_inv"}, (x.e * int'(d)) % x.phi, 1);
      check({tag, "_d_lt_phi"}, (int'(d) < x.phi), 1);
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_valid_hold"}, key_valid, x.valid);
  endtask

  task automatic run(input string tag, input int pp, input int qq, input int ee);
    do_start(pp, qq, ee);
    wait_done();
    check_result(tag, 1'b0);
  endtask

  initial begin
    int primes[6];
    primes = '{2, 3, 5, 7, 11, 13};
    rst_n = 1'b0;
    start = 1'b0;
    p     = '0;
    q     = '0;
    e     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", key_valid, 0);
    check("rst_err", key_err, 0);
    check("rst_n_out", n, 0);
    check("rst_d_out", d, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run("k3_11_7", 3, 11, 7);
    run("k5_11_3", 5, 11, 3);
    run("k5_11_17", 5, 11, 17);
    run("k3_5_9", 3, 5, 9);
    run("err_gcd", 3, 5, 6);
    run("err_p1", 1, 7, 3);
    run("err_e0", 3, 11, 0);

    // Start while busy and start during DONE are both ignored
    do_start(5, 11, 17);
    @(negedge clk);
    p = 4'd3; q = 4'd3; e = 9'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check_result("ignore_busy", 1'b1);
    check("no_accept_in_done", busy, 0);

    // Asynchronous reset in the middle of a division
    do_start(13, 11, 7);
    repeat (12) @(negedge clk);
    check("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_valid", key_valid, 0);
    check("abort_err", key_err, 0);
    check("abort_n", n, 0);
    check("abort_d", d, 0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    run("after_rst", 13, 11, 7);

    // Sweep of prime pairs with random exponents
    foreach (primes[i]) begin
      foreach (primes[j]) begin
        run("sweep", primes[i], primes[j], int'($urandom_range(0, 511)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
